call_ctrl: RTL and testbench
============================

# call_ctrl

Sequencing controller for the return stack (`stack`, 4-bit offset, PC_WIDTH entries) in the PLC CPU. It is the only driver of the stack's `call`/`ret`/`reset` inputs: it accepts one-hot call/return requests from the instruction decoder and asynchronous interrupt requests, serialises them into single-cycle stack operations, and redirects the PC. It also tracks stack depth, flags overflow/underflow as a sticky fault and flushes the stack after reset.

## Interface
- PC_WIDTH, 16, program-counter width; must match `stack`.
- DEPTH, 15, maximum live entries; must be ≤15 because the stack's 4-bit offset wraps at 16.
- IRQ_VECTOR, 0, ISR entry address, PC_WIDTH bits.

- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; all state to reset values immediately
- instr_call  in  1  decoder call request, sampled only when ready=1
- instr_ret  in  1  decoder return request
- irq_ret  in  1  return-from-interrupt request
- irq_req  in  1  level interrupt request
- pc_in  in  PC_WIDTH  address of the call instruction (call), or of the next unexecuted instruction (interrupt)
- call_target  in  PC_WIDTH  call destination
- stack_return_to  in  PC_WIDTH  stack top, combinational from `stack`
- fault_clear  in  1  leave FAULT
- ready  out  1  controller accepts a request this cycle
- stack_call, stack_ret, stack_reset  out  1  stack controls, never more than one high
- stack_called_from  out  PC_WIDTH  value stack stores plus one
- pc_load  out  1  load pc_next into PC this cycle
- pc_next  out  PC_WIDTH  PC redirect value
- irq_ack  out  1  one-cycle interrupt acknowledge
- in_isr  out  1  executing ISR; masks irq_req
- depth  out  $clog2(DEPTH+1)  live stack entries
- fault  out  1  sticky fault
- fault_code  out  2  1 overflow, 2 underflow, 3 irq_ret outside ISR

## Operation
- States: INIT, IDLE, EXEC, IRQ_VEC, FAULT. All outputs registered.
- Reset values: state INIT, every output 0 (including ready, stack_reset, pc_next, depth, in_isr, fault, fault_code).
- INIT: one cycle, stack_reset=1, depth:=0, in_isr:=0; then IDLE.
- IDLE: ready=1. Priority: irq_ret > instr_ret > instr_call > irq_req; lower simultaneous requests are dropped (decoder guarantees one-hot, irq_req is level and retried).
- Call: depth==DEPTH → FAULT code 1, no stack op. Otherwise EXEC: stack_call=1, stack_called_from=pc_in, pc_load=1, pc_next=call_target; depth+1 at end of EXEC.
- instr_ret: depth==0 → FAULT code 2. Otherwise EXEC: stack_ret=1, pc_load=1, pc_next=stack_return_to (sampled in EXEC, before pop edge); depth−1.
- irq_ret: in_isr==0 → FAULT code 3; depth==0 → FAULT code 2; otherwise as instr_ret and in_isr:=0 at end of EXEC.
- irq_req: taken only when in_isr==0 and depth<DEPTH; otherwise held pending, no fault. EXEC: stack_call=1, stack_called_from=pc_in−1 (mod 2^PC_WIDTH, so return resumes at pc_in), irq_ack=1; depth+1; then IRQ_VEC: pc_load=1, pc_next=IRQ_VECTOR, in_isr:=1; then IDLE.
- EXEC/IRQ_VEC/FAULT/INIT: ready=0.
- FAULT: fault=1, fault_code held, ready=0, no stack ops. fault_clear → INIT (flush, depth 0, fault:=0, fault_code:=0).

## Timing
- Request accepted at cycle N (ready=1) → stack op and pc_load at N+1, ready=1 again at N+2. Interrupt: stack_call+irq_ack at N+1, pc_load at N+2, ready at N+3.
- Fault detected at N → fault=1 from N+1.
- First ready after reset release: second rising edge (INIT, then IDLE).
- Reset asserted mid-EXEC: outputs drop immediately; any partial stack update is discarded by the INIT flush.
- depth changes only at the edge ending EXEC, in lockstep with the stack offset.

## Test plan
- Reset release → one cycle stack_reset=1, depth=0, ready=1 on next cycle; all other outputs 0.
- Call pc_in=0x0010, target=0x0100 → N+1: stack_call=1, called_from=0x0010, pc_next=0x0100; then instr_ret → pc_next=0x0011, depth back to 0.
- 15 nested calls then a 16th → depth=15, fault=1, fault_code=1, no 16th stack_call; fault_clear → INIT, depth=0.
- instr_ret at depth 0 → fault_code=2; irq_ret with in_isr=0 → fault_code=3.
- irq_req with pc_in=0x0020 → irq_ack, called_from=0x001F, pc_next=IRQ_VECTOR, in_isr=1; second irq_req ignored; irq_ret → pc_next=0x0020, in_isr=0.
- instr_call and irq_req together → call served first, interrupt taken at the next ready cycle; reset asserted in EXEC → all outputs 0 immediately.

Source files
------------

// File: rtl/call_ctrl.sv
// ---------------------------------------------------------------------------
// call_ctrl -- sequencing controller for the PLC CPU return stack.
//
// The only driver of the stack's call/ret/reset controls. Accepts one-hot
// call/return requests from the decoder plus a level interrupt request,
// serialises them into single-cycle stack operations, redirects the PC,
// tracks live stack depth and raises a sticky fault on overflow, underflow
// or a return-from-interrupt outside an ISR. The stack is flushed on every
// entry to INIT (after reset and after a fault is cleared).
//
// Handshake: a request is consumed only in a cycle where ready_o=1. The
// decoder requests are one-hot. irq_req_i is a level that stays high until
// it is acknowledged (irq_ack_o). A request that is lost to priority, or
// arrives while ready_o=0, is not remembered.
//
// Ports
//   clk_i              system clock, rising edge
//   rst_ni             asynchronous active-low reset
//   instr_call_i       decoder call request
//   instr_ret_i        decoder return request
//   irq_ret_i          return-from-interrupt request
//   irq_req_i          level interrupt request
//   pc_in_i            call instruction address / next instruction (irq)
//   call_target_i      call destination
//   stack_return_to_i  stack top (+1), combinational from the stack
//   fault_clear_i      leave FAULT
//   ready_o            request accepted this cycle
//   stack_call_o       push stack_called_from_o
//   stack_ret_o        pop
//   stack_reset_o      flush the stack
//   stack_called_from_o value pushed on stack_call_o
//   pc_load_o          load pc_next_o into the PC
//   pc_next_o          PC redirect value
//   irq_ack_o          one-cycle interrupt acknowledge
//   in_isr_o           executing an ISR (masks irq_req_i)
//   depth_o            live stack entries
//   fault_o            sticky fault
//   fault_code_o       1 overflow, 2 underflow, 3 irq_ret outside ISR
//   state_o            current FSM state (debug)
// ---------------------------------------------------------------------------
module call_ctrl #(
    parameter int                     PC_WIDTH   = 16,
    parameter int                     DEPTH      = 15,
    parameter logic [PC_WIDTH-1:0]    IRQ_VECTOR = '0,
    localparam int                    DW         = $clog2(DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                instr_call_i,
    input  logic                instr_ret_i,
    input  logic                irq_ret_i,
    input  logic                irq_req_i,
    input  logic [PC_WIDTH-1:0] pc_in_i,
    input  logic [PC_WIDTH-1:0] call_target_i,
    input  logic [PC_WIDTH-1:0] stack_return_to_i,
    input  logic                fault_clear_i,
    output logic                ready_o,
    output logic                stack_call_o,
    output logic                stack_ret_o,
    output logic                stack_reset_o,
    output logic [PC_WIDTH-1:0] stack_called_from_o,
    output logic                pc_load_o,
    output logic [PC_WIDTH-1:0] pc_next_o,
    output logic                irq_ack_o,
    output logic                in_isr_o,
    output logic [DW-1:0]       depth_o,
    output logic                fault_o,
    output logic [1:0]          fault_code_o,
    output logic [2:0]          state_o
);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_EXEC    = 3'd2,
        S_IRQ_VEC = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
    localparam logic [DW-1:0] ONE_D     = DW'(1);

    state_t                state_q;
    logic                  ready_q;
    logic                  stack_call_q;
    logic                  stack_ret_q;
    logic                  stack_reset_q;
    logic [PC_WIDTH-1:0]   called_from_q;
    logic                  pc_load_q;
    logic [PC_WIDTH-1:0]   pc_next_q;
    logic                  irq_ack_q;
    logic                  in_isr_q;
    logic [DW-1:0]         depth_q;
    logic                  fault_q;
    logic [1:0]            fault_code_q;
    // Set when the pop in EXEC is a return from interrupt, so in_isr
    // clears at the same edge as the depth decrement.
    logic                  isr_ret_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_INIT;
            ready_q       <= 1'b0;
            stack_call_q  <= 1'b0;
            stack_ret_q   <= 1'b0;
            stack_reset_q <= 1'b0;
            called_from_q <= '0;
            pc_load_q     <= 1'b0;
            pc_next_q     <= '0;
            irq_ack_q     <= 1'b0;
            in_isr_q      <= 1'b0;
            depth_q       <= '0;
            fault_q       <= 1'b0;
            fault_code_q  <= 2'd0;
            isr_ret_q     <= 1'b0;
        end else begin
            // Single-cycle pulses default low every cycle.
            ready_q       <= 1'b0;
            stack_call_q  <= 1'b0;
            stack_ret_q   <= 1'b0;
            stack_reset_q <= 1'b0;
            pc_load_q     <= 1'b0;
            irq_ack_q     <= 1'b0;

            case (state_q)
                S_INIT: begin
                    // Coming out of reset the flush pulse is not yet up, so
                    // INIT spends one cycle raising it; entry from FAULT
                    // raises it on the way in.
                    if (!stack_reset_q) begin
                        stack_reset_q <= 1'b1;
                        depth_q       <= '0;
                        in_isr_q      <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end

                S_IDLE: begin
                    if (irq_ret_i) begin
                        if (!in_isr_q) begin
                            state_q      <= S_FAULT;
                            fault_q      <= 1'b1;
                            fault_code_q <= 2'd3;
                        end else if (depth_q == '0) begin
                            state_q      <= S_FAULT;
                            fault_q      <= 1'b1;
                            fault_code_q <= 2'd2;
                        end else begin
                            // Stack top does not move until the pop edge at
                            // the end of EXEC, so sampling it here gives the
                            // same value as sampling it in EXEC.
                            state_q     <= S_EXEC;
                            stack_ret_q <= 1'b1;
                            pc_load_q   <= 1'b1;
                            pc_next_q   <= stack_return_to_i;
                            isr_ret_q   <= 1'b1;
                        end
                    end else if (instr_ret_i) begin
                        if (depth_q == '0) begin
                            state_q      <= S_FAULT;
                            fault_q      <= 1'b1;
                            fault_code_q <= 2'd2;
                        end else begin
                            state_q     <= S_EXEC;
                            stack_ret_q <= 1'b1;
                            pc_load_q   <= 1'b1;
                            pc_next_q   <= stack_return_to_i;
                        end
                    end else if (instr_call_i) begin
                        if (depth_q == DEPTH_MAX) begin
                            state_q      <= S_FAULT;
                            fault_q      <= 1'b1;
                            fault_code_q <= 2'd1;
                        end else begin
                            state_q       <= S_EXEC;
                            stack_call_q  <= 1'b1;
                            called_from_q <= pc_in_i;
                            pc_load_q     <= 1'b1;
                            pc_next_q     <= call_target_i;
                        end
                    end else if (irq_req_i && !in_isr_q && (depth_q < DEPTH_MAX)) begin
                        // The stack returns stored+1, so push pc_in-1 to
                        // resume at pc_in.
                        state_q       <= S_EXEC;
                        stack_call_q  <= 1'b1;
                        called_from_q <= pc_in_i - PC_WIDTH'(1);
                        irq_ack_q     <= 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end

                S_EXEC: begin
                    // Depth moves in lockstep with the stack offset.
                    if (stack_call_q) begin
                        depth_q <= depth_q + ONE_D;
                    end else if (stack_ret_q) begin
                        depth_q <= depth_q - ONE_D;
                    end
                    if (isr_ret_q) begin
                        in_isr_q <= 1'b0;
                    end
                    isr_ret_q <= 1'b0;
                    if (irq_ack_q) begin
                        state_q   <= S_IRQ_VEC;
                        pc_load_q <= 1'b1;
                        pc_next_q <= IRQ_VECTOR;
                        in_isr_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end

                S_IRQ_VEC: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end

                S_FAULT: begin
                    if (fault_clear_i) begin
                        state_q       <= S_INIT;
                        stack_reset_q <= 1'b1;
                        depth_q       <= '0;
                        in_isr_q      <= 1'b0;
                        fault_q       <= 1'b0;
                        fault_code_q  <= 2'd0;
                    end
                end

                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    assign ready_o             = ready_q;
    assign stack_call_o        = stack_call_q;
    assign stack_ret_o         = stack_ret_q;
    assign stack_reset_o       = stack_reset_q;
    assign stack_called_from_o = called_from_q;
    assign pc_load_o           = pc_load_q;
    assign pc_next_o           = pc_next_q;
    assign irq_ack_o           = irq_ack_q;
    assign in_isr_o            = in_isr_q;
    assign depth_o             = depth_q;
    assign fault_o             = fault_q;
    assign fault_code_o        = fault_code_q;
    assign state_o             = state_q;

endmodule

// File: tb/tb_call_ctrl.sv
module tb_call_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_call_i = 1'b0;
    logic        instr_ret_i = 1'b0;
    logic        irq_ret_i = 1'b0;
    logic        irq_req_i = 1'b0;
    logic [15:0] pc_in_i = '0;
    logic [15:0] call_target_i = '0;
    logic [15:0] stack_return_to_i;
    logic        fault_clear_i = 1'b0;
    logic        ready_o;
    logic        stack_call_o;
    logic        stack_ret_o;
    logic        stack_reset_o;
    logic [15:0] stack_called_from_o;
    logic        pc_load_o;
    logic [15:0] pc_next_o;
    logic        irq_ack_o;
    logic        in_isr_o;
    logic [3:0]  depth_o;
    logic        fault_o;
    logic [1:0]  fault_code_o;
    logic [2:0]  state_o;

    int n_tests = 0;
    int n_fail  = 0;

    call_ctrl #(.PC_WIDTH(16), .DEPTH(15), .IRQ_VECTOR(16'h0000)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_call_i(instr_call_i), .instr_ret_i(instr_ret_i),
        .irq_ret_i(irq_ret_i), .irq_req_i(irq_req_i),
        .pc_in_i(pc_in_i), .call_target_i(call_target_i),
        .stack_return_to_i(stack_return_to_i), .fault_clear_i(fault_clear_i),
        .ready_o(ready_o), .stack_call_o(stack_call_o), .stack_ret_o(stack_ret_o),
        .stack_reset_o(stack_reset_o), .stack_called_from_o(stack_called_from_o),
        .pc_load_o(pc_load_o), .pc_next_o(pc_next_o), .irq_ack_o(irq_ack_o),
        .in_isr_o(in_isr_o), .depth_o(depth_o), .fault_o(fault_o),
        .fault_code_o(fault_code_o), .state_o(state_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- return stack model ----------------
    // Stores called_from; top reads back stored value plus one.
    logic [15:0] stk_mem [16];
    logic [3:0]  stk_sp = 4'd0;
    logic [3:0]  stk_top_idx;
    assign stk_top_idx       = stk_sp - 4'd1;
    assign stack_return_to_i = stk_mem[stk_top_idx] + 16'd1;

    initial begin
        for (int i = 0; i < 16; i++) stk_mem[i] = '0;
    end

    always @(posedge clk_i) begin
        if (stack_reset_o) begin
            stk_sp <= 4'd0;
        end else if (stack_call_o) begin
            stk_mem[stk_sp] <= stack_called_from_o;
            stk_sp          <= stk_sp + 4'd1;
        end else if (stack_ret_o) begin
            stk_sp <= stk_sp - 4'd1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_req();
        instr_call_i  = 1'b0;
        instr_ret_i   = 1'b0;
        irq_ret_i     = 1'b0;
        irq_req_i     = 1'b0;
        fault_clear_i = 1'b0;
    endtask

    // Bounded wait for ready; timeout counts as a failed comparison.
    task automatic wait_ready();
        int n;
        n = 0;
        while (ready_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("wait_ready", {31'd0, ready_o}, 32'd1);
    endtask

    // One full call: request, EXEC, back in IDLE.
    task automatic do_call(input logic [15:0] pc, input logic [15:0] tgt);
        pc_in_i       = pc;
        call_target_i = tgt;
        instr_call_i  = 1'b1;
        tick();
        clear_req();
        check("nest_call_pulse", {31'd0, stack_call_o}, 32'd1);
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        #1;
        check("rst_ready", {31'd0, ready_o}, 32'd0);
        check("rst_stack_reset", {31'd0, stack_reset_o}, 32'd0);
        check("rst_outs", {16'd0, pc_next_o}, 32'd0);
        check("rst_misc", {24'd0, depth_o, in_isr_o, fault_o, fault_code_o}, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        check("init_stack_reset", {31'd0, stack_reset_o}, 32'd1);
        check("init_ready", {31'd0, ready_o}, 32'd0);
        check("init_depth", {28'd0, depth_o}, 32'd0);
        tick();
        check("idle_ready", {31'd0, ready_o}, 32'd1);
        check("idle_stack_reset", {31'd0, stack_reset_o}, 32'd0);
        check("idle_quiet", {26'd0, stack_call_o, stack_ret_o, pc_load_o,
                             irq_ack_o, in_isr_o, fault_o}, 32'd0);

        // Call then return
        pc_in_i = 16'h0010; call_target_i = 16'h0100; instr_call_i = 1'b1;
        tick();
        clear_req();
        check("call_stack_call", {31'd0, stack_call_o}, 32'd1);
        check("call_from", {16'd0, stack_called_from_o}, 32'h0010);
        check("call_pc_next", {16'd0, pc_next_o}, 32'h0100);
        check("call_pc_load", {31'd0, pc_load_o}, 32'd1);
        check("call_ready_low", {31'd0, ready_o}, 32'd0);
        check("call_depth_exec", {28'd0, depth_o}, 32'd0);
        tick();
        check("call_ready_back", {31'd0, ready_o}, 32'd1);
        check("call_depth", {28'd0, depth_o}, 32'd1);
        instr_ret_i = 1'b1;
        tick();
        clear_req();
        check("ret_stack_ret", {31'd0, stack_ret_o}, 32'd1);
        check("ret_pc_next", {16'd0, pc_next_o}, 32'h0011);
        check("ret_pc_load", {31'd0, pc_load_o}, 32'd1);
        tick();
        check("ret_depth", {28'd0, depth_o}, 32'd0);
        check("ret_ready", {31'd0, ready_o}, 32'd1);

        // 15 nested calls, 16th overflows
        for (int i = 0; i < 15; i++) begin
            do_call(16'(16'h0100 + i * 4), 16'(16'h0800 + i * 16));
        end
        check("nest_depth15", {28'd0, depth_o}, 32'd15);
        check("nest_ready", {31'd0, ready_o}, 32'd1);
        pc_in_i = 16'h0300; instr_call_i = 1'b1;
        tick();
        clear_req();
        check("ovf_fault", {31'd0, fault_o}, 32'd1);
        check("ovf_code", {30'd0, fault_code_o}, 32'd1);
        check("ovf_no_call", {31'd0, stack_call_o}, 32'd0);
        check("ovf_depth", {28'd0, depth_o}, 32'd15);
        tick(); tick();
        check("ovf_sticky", {29'd0, fault_o, fault_code_o}, 32'h5);
        check("ovf_not_ready", {31'd0, ready_o}, 32'd0);
        fault_clear_i = 1'b1;
        tick();
        clear_req();
        check("clr_stack_reset", {31'd0, stack_reset_o}, 32'd1);
        check("clr_fault", {29'd0, fault_o, fault_code_o}, 32'd0);
        check("clr_depth", {28'd0, depth_o}, 32'd0);
        tick();
        check("clr_ready", {31'd0, ready_o}, 32'd1);

        // Underflow and irq_ret outside ISR
        instr_ret_i = 1'b1;
        tick();
        clear_req();
        check("unf_code", {29'd0, fault_o, fault_code_o}, 32'h6);
        fault_clear_i = 1'b1; tick(); clear_req(); tick();
        irq_ret_i = 1'b1;
        tick();
        clear_req();
        check("iret_code", {29'd0, fault_o, fault_code_o}, 32'h7);
        fault_clear_i = 1'b1; tick(); clear_req(); tick();
        check("iret_clr_ready", {31'd0, ready_o}, 32'd1);

        // Interrupt entry, masking, and return
        pc_in_i = 16'h0020; irq_req_i = 1'b1;
        tick();
        check("irq_ack", {31'd0, irq_ack_o}, 32'd1);
        check("irq_call", {31'd0, stack_call_o}, 32'd1);
        check("irq_from", {16'd0, stack_called_from_o}, 32'h001F);
        check("irq_no_load", {31'd0, pc_load_o}, 32'd0);
        tick();
        check("vec_load", {31'd0, pc_load_o}, 32'd1);
        check("vec_pc", {16'd0, pc_next_o}, 32'h0000);
        check("vec_in_isr", {31'd0, in_isr_o}, 32'd1);
        check("vec_ready", {31'd0, ready_o}, 32'd0);
        tick();
        check("isr_ready", {31'd0, ready_o}, 32'd1);
        check("isr_depth", {28'd0, depth_o}, 32'd1);
        // irq_req still high while in ISR: must be ignored
        for (int i = 0; i < 3; i++) begin
            tick();
            check("irq_masked", {29'd0, irq_ack_o, stack_call_o, ready_o}, 32'd1);
        end
        clear_req();
        irq_ret_i = 1'b1;
        tick();
        clear_req();
        check("iret_stack_ret", {31'd0, stack_ret_o}, 32'd1);
        check("iret_pc_next", {16'd0, pc_next_o}, 32'h0020);
        check("iret_in_isr_exec", {31'd0, in_isr_o}, 32'd1);
        tick();
        check("iret_in_isr", {31'd0, in_isr_o}, 32'd0);
        check("iret_depth", {28'd0, depth_o}, 32'd0);

        // Simultaneous call and irq: call first, irq on next ready
        pc_in_i = 16'h0040; call_target_i = 16'h0200;
        instr_call_i = 1'b1; irq_req_i = 1'b1;
        tick();
        instr_call_i = 1'b0; pc_in_i = 16'h0205;
        check("both_call", {29'd0, stack_call_o, irq_ack_o, pc_load_o}, 32'h5);
        check("both_from", {16'd0, stack_called_from_o}, 32'h0040);
        tick();
        check("both_ready", {31'd0, ready_o}, 32'd1);
        tick();
        clear_req();
        check("both_irq_ack", {30'd0, irq_ack_o, stack_call_o}, 32'h3);
        check("both_irq_from", {16'd0, stack_called_from_o}, 32'h0204);
        wait_ready();
        check("both_depth", {28'd0, depth_o}, 32'd2);

        // Reset asserted mid-EXEC
        irq_ret_i = 1'b1;
        tick();
        clear_req();
        check("rexec_ret", {31'd0, stack_ret_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check("rexec_outs", {27'd0, stack_ret_o, pc_load_o, ready_o, in_isr_o, fault_o}, 32'd0);
        check("rexec_pc", {16'd0, pc_next_o}, 32'd0);
        check("rexec_depth", {28'd0, depth_o}, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        check("rexec_flush", {31'd0, stack_reset_o}, 32'd1);
        tick();
        check("rexec_ready", {31'd0, ready_o}, 32'd1);
        check("rexec_sp", {28'd0, stk_sp}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
